// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter that time-shares one combinational ALU.
// Optional macro ALU_RR_ARBITER_OPCHK_EN squashes opcodes 5..7 and raises rsp_err.
module alu_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_op,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_err,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [2:0]            alu_opcode,
   input  logic [WIDTH-1:0]      alu_result
);

   if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0) begin : g_bad_nreq
      $error("alu_rr_arbiter: NREQ must be a power of two in 2..8");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [IDW-1:0]   rr_ptr_q;
   logic [IDW-1:0]   rr_ptr_d;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_a_d;
   logic [WIDTH-1:0] alu_b_q;
   logic [WIDTH-1:0] alu_b_d;
   logic [2:0]       alu_op_q;
   logic [2:0]       alu_op_d;
   logic             rsp_valid_q;
   logic             rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q;
   logic [IDW-1:0]   rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q;
   logic [WIDTH-1:0] rsp_result_d;

   logic             gnt_vld;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   scan_idx;
   logic [NREQ-1:0]  gnt_oh;
   logic [WIDTH-1:0] gnt_a;
   logic [WIDTH-1:0] gnt_b;
   logic [2:0]       gnt_op;
   logic             in_idle;

`ifdef ALU_RR_ARBITER_OPCHK_EN
   logic             op_bad;
   logic             err_q;
   logic             err_d;
   logic             rsp_err_q;
   logic             rsp_err_d;
`endif

   assign in_idle = (state_q == ST_IDLE);

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = rr_ptr_q + IDW'(k);
         if (!gnt_vld && req_valid[scan_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // Winner's fields and one-hot strobe.
   always_comb begin
      gnt_oh          = '0;
      gnt_oh[gnt_idx] = gnt_vld;
      gnt_a           = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
      gnt_b           = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
      gnt_op          = req_op[int'(gnt_idx)*3 +: 3];
   end

   // Acceptance only in IDLE; held low during reset regardless of state.
   assign req_ready = (in_idle && rst_n) ? gnt_oh : '0;

`ifdef ALU_RR_ARBITER_OPCHK_EN
   assign op_bad = (gnt_op > 3'd4);
`endif

   // Next-state logic: grant, one settling cycle, then hold the response.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
`ifdef ALU_RR_ARBITER_OPCHK_EN
      err_d        = err_q;
      rsp_err_d    = rsp_err_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               alu_a_d  = gnt_a;
               alu_b_d  = gnt_b;
               alu_op_d = gnt_op;
               rsp_id_d = gnt_idx;
               rr_ptr_d = gnt_idx + 1'b1;
               state_d  = ST_EXEC;
`ifdef ALU_RR_ARBITER_OPCHK_EN
               err_d    = op_bad;
               if (op_bad) begin
                  alu_op_d = 3'd0;
               end
`endif
            end
         end
         ST_EXEC: begin
            rsp_result_d = alu_result;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
`ifdef ALU_RR_ARBITER_OPCHK_EN
            rsp_err_d    = err_q;
            if (err_q) begin
               rsp_result_d = '0;
            end
`endif
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
      end
   end

`ifdef ALU_RR_ARBITER_OPCHK_EN
   // Illegal-opcode tracking from grant through response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q     <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         err_q     <= err_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and randomized bench for alu_rr_arbiter.
// A behavioural ALU closes the loop; a transaction-level model predicts outputs.
`timescale 1ns/1ps
module tb_alu_rr_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

`ifdef ALU_RR_ARBITER_OPCHK_EN
   localparam bit OPCHK = 1'b1;
`else
   localparam bit OPCHK = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*3-1:0]     req_op;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_err;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [2:0]            alu_opcode;
   logic [WIDTH-1:0]      alu_result;

   alu_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_a, alu_b, alu_opcode);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // requester-side pending requests
   bit               p_valid[NREQ];
   logic [WIDTH-1:0] p_a[NREQ];
   logic [WIDTH-1:0] p_b[NREQ];
   logic [2:0]       p_op[NREQ];
   bit               p_rsp_ready;

   // transaction-level model
   int               m_ptr;
   bit               m_busy;
   bit               m_rv;
   int               m_id;
   logic [WIDTH-1:0] m_res;
   logic [WIDTH-1:0] m_a;
   logic [WIDTH-1:0] m_b;
   logic [2:0]       m_op;
   bit               m_err;

   logic [NREQ-1:0]  rdy_seen;
   bit               hs_seen;
   int               hs_id;
   logic [WIDTH-1:0] hs_res;

   task automatic arm(input int i, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [2:0] op);
      p_valid[i] = 1'b1;
      p_a[i]     = a;
      p_b[i]     = b;
      p_op[i]    = op;
   endtask

   // One clock: check registered outputs, drive, check strobe, advance model.
   task automatic step();
      int g;
      logic [NREQ-1:0] exp_rdy;
      @(negedge clk);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
         chk("rsp_id", rsp_id, m_id);
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_err", rsp_err, m_err);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_opcode", alu_opcode, m_op);
      end
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]             = p_valid[i];
         req_a[i*WIDTH +: WIDTH]  = p_a[i];
         req_b[i*WIDTH +: WIDTH]  = p_b[i];
         req_op[i*3 +: 3]         = p_op[i];
      end
      rsp_ready = p_rsp_ready;
      #1;
      g = -1;
      if (!m_busy) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && p_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      rdy_seen = req_ready;
      hs_seen  = m_rv && p_rsp_ready;
      hs_id    = m_id;
      hs_res   = m_res;
      @(posedge clk);
      #1;
      if (m_rv) begin
         if (p_rsp_ready) begin
            m_rv   = 1'b0;
            m_busy = 1'b0;
         end
      end else if (m_busy) begin
         m_rv = 1'b1;
      end else if (g >= 0) begin
         m_busy     = 1'b1;
         m_id       = g;
         m_a        = p_a[g];
         m_b        = p_b[g];
         m_err      = OPCHK && (p_op[g] > 3'd4);
         m_op       = m_err ? 3'd0 : p_op[g];
         m_res      = m_err ? '0 : alu_fn(p_a[g], p_b[g], p_op[g]);
         m_ptr      = (g + 1) % NREQ;
         p_valid[g] = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      m_busy = 1'b0;
      m_rv   = 1'b0;
      m_ptr  = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
      p_rsp_ready = 1'b1;
      repeat (n) step();
   endtask

   int          rr_ids[$];
   int          rr_res[$];
   int          rr_exp_id[5] = '{0, 1, 2, 3, 0};
   int          cnt;

   initial begin
      rst_n     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) arm(i, '0, '0, 3'd0);
      for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
      p_rsp_ready = 1'b1;
      m_id = 0; m_res = '0; m_a = '0; m_b = '0; m_op = '0; m_err = 1'b0;
      #2;
      pulse_reset();

      // reset mid-transaction while everyone requests
      for (int i = 0; i < NREQ; i++) arm(i, WIDTH'(i + 1), 8'h03, 3'd0);
      repeat (4) step();
      pulse_reset();

      // round robin with all requesters held valid
      for (int s = 0; s < 15; s++) begin
         for (int i = 0; i < NREQ; i++) arm(i, WIDTH'(i), 8'd10, 3'd0);
         step();
         if (s == 0) chk("rst_first_grant", rdy_seen, 4'b0001);
         chk("rr_onehot", $onehot0(rdy_seen), 1);
         if (hs_seen) begin
            rr_ids.push_back(hs_id);
            rr_res.push_back(int'(hs_res));
         end
      end
      chk("rr_count", rr_ids.size(), 5);
      for (int j = 0; j < rr_ids.size() && j < 5; j++) begin
         chk("rr_id", rr_ids[j], rr_exp_id[j]);
         chk("rr_result", rr_res[j], 10 + rr_exp_id[j]);
      end
      idle(3);

      // single request, SUB
      arm(2, 8'd20, 8'd5, 3'd1);
      step();
      chk("single_rdy", rdy_seen, 4'b0100);
      step();
      chk("single_rdy_off", rdy_seen, 4'b0000);
      chk("single_valid", rsp_valid, 1);
      chk("single_id", rsp_id, 2);
      chk("single_result", rsp_result, 15);
      step();
      chk("single_done", rsp_valid, 0);
      idle(2);

      // backpressure with wrapping ADD
      arm(0, 8'hF0, 8'h20, 3'd0);
      p_rsp_ready = 1'b0;
      step();
      step();
      arm(3, 8'h11, 8'h22, 3'd2);
      repeat (5) begin
         step();
         chk("bp_valid", rsp_valid, 1);
         chk("bp_result", rsp_result, 8'h10);
         chk("bp_rdy", rdy_seen, 4'b0000);
      end
      p_rsp_ready = 1'b1;
      step();
      chk("bp_hs", hs_seen, 1);
      chk("bp_done", rsp_valid, 0);
      step();
      chk("bp_next", rdy_seen, 4'b1000);
      idle(4);

      // reset while a response is being held
      arm(1, 8'd7, 8'd9, 3'd3);
      p_rsp_ready = 1'b0;
      step();
      step();
      chk("rr_resp_valid", rsp_valid, 1);
      pulse_reset();
      cnt = 0;
      for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
      p_rsp_ready = 1'b1;
      repeat (5) begin
         step();
         cnt += int'(rsp_valid);
      end
      chk("rst_drop", cnt, 0);

      // illegal opcode from requester 1
      arm(1, 8'h33, 8'h0F, 3'd6);
      step();
      step();
      chk("ill_opcode", alu_opcode, OPCHK ? 3'd0 : 3'd6);
      chk("ill_err", rsp_err, OPCHK);
      chk("ill_id", rsp_id, 1);
      chk("ill_result", rsp_result, OPCHK ? 8'h00 : 8'hCC);
      idle(2);

      // randomized traffic with withdrawals and backpressure
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!p_valid[i]) begin
               if ($urandom_range(2) == 0) begin
                  arm(i, ($urandom_range(7) == 0) ? 8'hFF : WIDTH'($urandom),
                      WIDTH'($urandom), 3'($urandom));
               end
            end else if ($urandom_range(19) == 0) begin
               p_valid[i] = 1'b0;
            end
         end
         p_rsp_ready = ($urandom_range(3) != 0);
         step();
         if (c == 1500) pulse_reset();
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational `alu` instance (WIDTH-bit A/B, 3-bit opcode, WIDTH-bit result) between NREQ requesters.
- Uses round-robin arbitration with a valid/ready handshake on each request port and a single response channel with backpressure.
- Drives the ALU operand and opcode inputs from registers and samples the ALU result one cycle later.
- Sits between the requesting datapath units and the shared `alu`, which is instantiated alongside it at the parent level.

Parameters:
- WIDTH, 8, operand/result width; must match the `alu` instance's WIDTH.
- NREQ, 4, number of requesters; a power of two in the range 2..8.
- IDW, $clog2(NREQ), localparam; requester-ID width.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  packed operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing as req_a.
- req_op  in  NREQ*3  packed opcode; requester i occupies [i*3 +: 3].
- req_ready  out  NREQ  one-hot acceptance strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_err  out  1  illegal-opcode flag; see Optional Feature.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_opcode  out  3  registered opcode to the ALU.
- alu_result  in  WIDTH  combinational result from the ALU.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_result, rsp_err all 0.
  - req_ready is forced to 0 while rst_n is low.
  - Reset mid-transaction drops the in-flight request silently; no response is issued.
- ALU opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR. Results are mod 2^WIDTH; carry and borrow are discarded.
- FSM, state IDLE:
  - Grant g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the clock edge: alu_a/alu_b/alu_opcode <= requester g's fields; rsp_id <= g; rr_ptr <= (g+1) mod NREQ; state -> EXEC.
  - With no valid request: stay in IDLE; rr_ptr is unchanged.
- FSM, state EXEC (1 cycle, ALU settling):
  - rsp_result <= alu_result, rsp_valid <= 1, state -> RESP.
- FSM, state RESP:
  - Hold rsp_valid, rsp_id, rsp_result and rsp_err stable.
  - If rsp_ready=1: rsp_valid <= 0, state -> IDLE.
  - alu_a/alu_b/alu_opcode also stay stable until the next grant.
- req_ready is 0 in EXEC and RESP; new requests wait.
- Latency: grant at edge T gives rsp_valid high after edge T+2.
  - Minimum occupancy is 3 cycles per transaction (rsp_ready held high).
  - The next grant can occur in the cycle after the response handshake.
- Requester rules:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - Deasserting req_valid before a grant is legal (request withdrawn).
- Simultaneous valid requests: serviced strictly in round-robin order; no requester waits more than NREQ-1 transactions.

Optional Feature:
- Macro: ALU_RR_ARBITER_OPCHK_EN.
- Defined:
  - A granted opcode of 5..7 loads alu_opcode <= 0 and sets an err flag.
  - In EXEC: rsp_result <= 0 and rsp_err <= 1.
  - Latency and handshake are identical to the legal-opcode case.
  - rsp_err <= 0 for legal opcodes.
- Undefined:
  - The opcode passes to the ALU unchanged.
  - rsp_err is tied to 0.
  - The result is whatever the ALU returns.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req_valid=4'hF -> all outputs 0 and req_ready=0 immediately; after release, the first grant goes to requester 0.
- Single request: req_valid=4'b0100, A=20, B=5, op=1, rsp_ready=1 -> req_ready=4'b0100 for one cycle; two edges later rsp_valid=1, rsp_id=2, rsp_result=15.
- Round-robin: req_valid=4'hF held, each requester op=0 with A=i, B=10 -> responses in order id 0,1,2,3,0 with results 10,11,12,13,10; each req_ready pulse is one-hot.
- Backpressure: A=8'hF0, B=8'h20, op=0, rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_result=8'h10 (wrapped) held stable; no req_ready pulses; handshake completes on the cycle rsp_ready=1.
- Reset in RESP: rsp_ready=0, then pulse rst_n low -> rsp_valid drops to 0 asynchronously; no response for the dropped request after release.
- Illegal opcode (ALU_RR_ARBITER_OPCHK_EN defined): op=6 from requester 1 -> alu_opcode=0, rsp_err=1, rsp_result=0, rsp_id=1.
- Illegal opcode (macro undefined): op=6 from requester 1 -> alu_opcode=6, rsp_err=0.
